// File: rtl/control_unit_pkg.sv
// Shared types for the hardwired control unit: opcodes, FSM states, op classes, ALU select indices.
package control_unit_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam int ALU_W   = 12;
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_MUL = 2;
    localparam int ALU_DIV = 3;
    localparam int ALU_SHR = 4;
    localparam int ALU_SHL = 5;
    localparam int ALU_ROR = 6;
    localparam int ALU_ROL = 7;
    localparam int ALU_AND = 8;
    localparam int ALU_OR  = 9;
    localparam int ALU_NEG = 10;
    localparam int ALU_NOT = 11;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } cu_state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_MULDIV, C_UNARY, C_IMM, C_LDI, C_LD, C_ST, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } op_class_t;

    // Final execute state of each class; the FSM returns to T0 (or HALT on stop) from here.
    function automatic cu_state_t last_state(input op_class_t c);
        case (c)
            C_ALU3, C_MULDIV, C_IMM, C_LDI: return S_T5;
            C_UNARY:                        return S_T4;
            C_LD, C_ST:                     return S_T7;
            C_BR:                           return S_T6;
            default:                        return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control unit <-> datapath bundle: IR/CON/stop toward the sequencer, strobes back out.
interface control_unit_if
    import control_unit_pkg::*;
#(
    parameter int BITS = 32
);
    logic [BITS-1:0] ir;
    logic            con;
    logic            stop;
    logic            dp_reset, run, illegal, hi_sel;
    logic            PCout, MARin, IncPC, RZin, RZout, PCin, Read, Write, MDRin, MDRout, IRin;
    logic            Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, RYin, HILOin, HILOout;
    logic            INPUTout, OUTPUTin;
    logic            ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT;
    cu_state_t       state;

    // Strobes are level signals valid for one full clock; there is no handshake back-pressure.
    modport master (
        input  ir, con, stop,
        output dp_reset, run, illegal, hi_sel,
        output PCout, MARin, IncPC, RZin, RZout, PCin, Read, Write, MDRin, MDRout, IRin,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, RYin, HILOin, HILOout,
        output INPUTout, OUTPUTin,
        output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
        output state
    );

    modport slave (
        output ir, con, stop,
        input  dp_reset, run, illegal, hi_sel,
        input  PCout, MARin, IncPC, RZin, RZout, PCin, Read, Write, MDRin, MDRout, IRin,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, RYin, HILOin, HILOout,
        input  INPUTout, OUTPUTin,
        input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT,
        input  state
    );
endinterface

// File: rtl/control_unit_op_decoder.sv
// Combinational opcode decode: instruction class, one-hot ALU function, illegal flag.
module control_unit_op_decoder
    import control_unit_pkg::*;
(
    input  logic [4:0]       i_op,
    output op_class_t        o_class,
    output logic [ALU_W-1:0] o_alu,
    output logic             o_illegal
);
    always_comb begin
        o_class = C_ILL;
        o_alu   = '0;
        case (i_op)
            OP_LD:   begin o_class = C_LD;     o_alu[ALU_ADD] = 1'b1; end
            OP_LDI:  begin o_class = C_LDI;    o_alu[ALU_ADD] = 1'b1; end
            OP_ST:   begin o_class = C_ST;     o_alu[ALU_ADD] = 1'b1; end
            OP_ADD:  begin o_class = C_ALU3;   o_alu[ALU_ADD] = 1'b1; end
            OP_SUB:  begin o_class = C_ALU3;   o_alu[ALU_SUB] = 1'b1; end
            OP_SHR:  begin o_class = C_ALU3;   o_alu[ALU_SHR] = 1'b1; end
            OP_SHL:  begin o_class = C_ALU3;   o_alu[ALU_SHL] = 1'b1; end
            OP_ROR:  begin o_class = C_ALU3;   o_alu[ALU_ROR] = 1'b1; end
            OP_ROL:  begin o_class = C_ALU3;   o_alu[ALU_ROL] = 1'b1; end
            OP_AND:  begin o_class = C_ALU3;   o_alu[ALU_AND] = 1'b1; end
            OP_OR:   begin o_class = C_ALU3;   o_alu[ALU_OR]  = 1'b1; end
            OP_ADDI: begin o_class = C_IMM;    o_alu[ALU_ADD] = 1'b1; end
            OP_ANDI: begin o_class = C_IMM;    o_alu[ALU_AND] = 1'b1; end
            OP_ORI:  begin o_class = C_IMM;    o_alu[ALU_OR]  = 1'b1; end
            OP_MUL:  begin o_class = C_MULDIV; o_alu[ALU_MUL] = 1'b1; end
            OP_DIV:  begin o_class = C_MULDIV; o_alu[ALU_DIV] = 1'b1; end
            OP_NEG:  begin o_class = C_UNARY;  o_alu[ALU_NEG] = 1'b1; end
            OP_NOT:  begin o_class = C_UNARY;  o_alu[ALU_NOT] = 1'b1; end
            OP_BR:   begin o_class = C_BR;     o_alu[ALU_ADD] = 1'b1; end
            OP_JR:   o_class = C_JR;
            OP_IN:   o_class = C_IN;
            OP_OUT:  o_class = C_OUT;
            OP_MFHI: o_class = C_MFHI;
            OP_MFLO: o_class = C_MFLO;
            OP_NOP:  o_class = C_NOP;
            OP_HALT: o_class = C_HALT;
            default: o_class = C_ILL;
        endcase
    end

    assign o_illegal = (o_class == C_ILL);
endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, decode at T3, per-class execute, HALT on halt/illegal/stop.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int BITS = 32,
    parameter int OPW  = 5
)(
    input  logic          clk,
    input  logic          reset,
    control_unit_if.master bus
);
    cu_state_t        r_state, w_next;
    logic [OPW-1:0]   r_op;
    logic             r_illegal;
    op_class_t        w_cls;
    logic [ALU_W-1:0] w_alu;
    logic             w_ill;
    logic             w_alu_en;
    logic             w_unused_ir;

    assign w_unused_ir = ^bus.ir[BITS-OPW-1:0];

    control_unit_op_decoder u_dec (
        .i_op      (r_op),
        .o_class   (w_cls),
        .o_alu     (w_alu),
        .o_illegal (w_ill)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RST;
            r_op      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2)
                r_op <= bus.ir[BITS-1 -: OPW];
            if (r_state == S_T3 && w_ill)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:  w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   w_next = S_T2;
            S_T2:   w_next = S_T3;
            S_HALT: w_next = S_HALT;
            default: begin
                if (r_state == S_T3 && (w_cls == C_HALT || w_ill))
                    w_next = S_HALT;
                else if (r_state == last_state(w_cls))
                    w_next = bus.stop ? S_HALT : S_T0;
                else
                    w_next = cu_state_t'(r_state + 4'd1);
            end
        endcase
    end

    always_comb begin
        bus.PCout = 1'b0;  bus.MARin = 1'b0;  bus.IncPC = 1'b0;    bus.RZin = 1'b0;
        bus.RZout = 1'b0;  bus.PCin = 1'b0;   bus.Read = 1'b0;     bus.Write = 1'b0;
        bus.MDRin = 1'b0;  bus.MDRout = 1'b0; bus.IRin = 1'b0;     bus.Gra = 1'b0;
        bus.Grb = 1'b0;    bus.Grc = 1'b0;    bus.Rin = 1'b0;      bus.Rout = 1'b0;
        bus.BAout = 1'b0;  bus.Cout = 1'b0;   bus.CONin = 1'b0;    bus.RYin = 1'b0;
        bus.HILOin = 1'b0; bus.HILOout = 1'b0; bus.INPUTout = 1'b0; bus.OUTPUTin = 1'b0;
        bus.hi_sel = 1'b0;
        w_alu_en   = 1'b0;
        case (r_state)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.RZin = 1'b1; end
            S_T1: begin bus.RZout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: case (w_cls)
                C_ALU3, C_IMM:     begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.RYin = 1'b1; end
                C_LDI, C_LD, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.RYin = 1'b1; end
                C_MULDIV:          begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.RYin = 1'b1; end
                C_UNARY:           begin bus.Grb = 1'b1; bus.Rout = 1'b1; w_alu_en = 1'b1; bus.RZin = 1'b1; end
                C_BR:              begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                C_JR:              begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                C_IN:              begin bus.INPUTout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_OUT:             begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OUTPUTin = 1'b1; end
                C_MFHI:            begin bus.HILOout = 1'b1; bus.hi_sel = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_MFLO:            begin bus.HILOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                default: ;
            endcase
            S_T4: case (w_cls)
                C_ALU3:   begin bus.Grc = 1'b1; bus.Rout = 1'b1; w_alu_en = 1'b1; bus.RZin = 1'b1; end
                C_MULDIV: begin bus.Grb = 1'b1; bus.Rout = 1'b1; w_alu_en = 1'b1; bus.RZin = 1'b1; end
                C_UNARY:  begin bus.RZout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_IMM, C_LDI, C_LD, C_ST:
                          begin bus.Cout = 1'b1; w_alu_en = 1'b1; bus.RZin = 1'b1; end
                C_BR:     begin bus.PCout = 1'b1; bus.RYin = 1'b1; end
                default: ;
            endcase
            S_T5: case (w_cls)
                C_ALU3, C_IMM, C_LDI: begin bus.RZout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_MULDIV:             begin bus.RZout = 1'b1; bus.HILOin = 1'b1; end
                C_LD, C_ST:           begin bus.RZout = 1'b1; bus.MARin = 1'b1; end
                C_BR:                 begin bus.Cout = 1'b1; w_alu_en = 1'b1; bus.RZin = 1'b1; end
                default: ;
            endcase
            // Branch target is committed only when the CON flag says taken.
            S_T6: case (w_cls)
                C_LD: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
                C_ST: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
                C_BR: begin bus.RZout = 1'b1; bus.PCin = bus.con; end
                default: ;
            endcase
            S_T7: case (w_cls)
                C_LD: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                C_ST: bus.Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

    assign bus.ADD    = w_alu_en & w_alu[ALU_ADD];
    assign bus.SUB    = w_alu_en & w_alu[ALU_SUB];
    assign bus.MUL    = w_alu_en & w_alu[ALU_MUL];
    assign bus.DIV    = w_alu_en & w_alu[ALU_DIV];
    assign bus.SHR    = w_alu_en & w_alu[ALU_SHR];
    assign bus.SHL    = w_alu_en & w_alu[ALU_SHL];
    assign bus.ROR    = w_alu_en & w_alu[ALU_ROR];
    assign bus.ROL    = w_alu_en & w_alu[ALU_ROL];
    assign bus.AND    = w_alu_en & w_alu[ALU_AND];
    assign bus.OR     = w_alu_en & w_alu[ALU_OR];
    assign bus.NEGATE = w_alu_en & w_alu[ALU_NEG];
    assign bus.NOT    = w_alu_en & w_alu[ALU_NOT];

    assign bus.dp_reset = (r_state == S_RST);
    assign bus.run      = (r_state != S_HALT);
    assign bus.illegal  = r_illegal;
    assign bus.state    = r_state;
endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected strobe words queued per instruction.
module tb_control_unit;
    import control_unit_pkg::*;

    localparam int W = 40;
    localparam int B_PCOUT = 0,   B_MARIN = 1,   B_INCPC = 2,  B_RZIN = 3,    B_RZOUT = 4;
    localparam int B_PCIN = 5,    B_READ = 6,    B_WRITE = 7,  B_MDRIN = 8,   B_MDROUT = 9;
    localparam int B_IRIN = 10,   B_GRA = 11,    B_GRB = 12,   B_GRC = 13,    B_RIN = 14;
    localparam int B_ROUT = 15,   B_BAOUT = 16,  B_COUT = 17,  B_CONIN = 18,  B_RYIN = 19;
    localparam int B_HILOIN = 20, B_HILOOUT = 21, B_INOUT = 22, B_OUTIN = 23;
    localparam int B_ADD = 24, B_SUB = 25, B_MUL = 26, B_DIV = 27, B_SHR = 28, B_SHL = 29;
    localparam int B_ROR = 30, B_ROL = 31, B_AND = 32, B_OR = 33, B_NEG = 34, B_NOT = 35;
    localparam int B_HISEL = 36, B_DPRST = 37, B_RUN = 38, B_ILL = 39;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic exp_ill;
    logic [W-1:0] exp_q[$];

    control_unit_if #(.BITS(32)) bus ();

    control_unit #(.BITS(32), .OPW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] m(input int i);
        logic [W-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] dut_word();
        logic [W-1:0] v;
        v = '0;
        v[B_PCOUT] = bus.PCout;   v[B_MARIN] = bus.MARin;   v[B_INCPC] = bus.IncPC;
        v[B_RZIN] = bus.RZin;     v[B_RZOUT] = bus.RZout;   v[B_PCIN] = bus.PCin;
        v[B_READ] = bus.Read;     v[B_WRITE] = bus.Write;   v[B_MDRIN] = bus.MDRin;
        v[B_MDROUT] = bus.MDRout; v[B_IRIN] = bus.IRin;     v[B_GRA] = bus.Gra;
        v[B_GRB] = bus.Grb;       v[B_GRC] = bus.Grc;       v[B_RIN] = bus.Rin;
        v[B_ROUT] = bus.Rout;     v[B_BAOUT] = bus.BAout;   v[B_COUT] = bus.Cout;
        v[B_CONIN] = bus.CONin;   v[B_RYIN] = bus.RYin;     v[B_HILOIN] = bus.HILOin;
        v[B_HILOOUT] = bus.HILOout; v[B_INOUT] = bus.INPUTout; v[B_OUTIN] = bus.OUTPUTin;
        v[B_ADD] = bus.ADD; v[B_SUB] = bus.SUB; v[B_MUL] = bus.MUL; v[B_DIV] = bus.DIV;
        v[B_SHR] = bus.SHR; v[B_SHL] = bus.SHL; v[B_ROR] = bus.ROR; v[B_ROL] = bus.ROL;
        v[B_AND] = bus.AND; v[B_OR] = bus.OR;   v[B_NEG] = bus.NEGATE; v[B_NOT] = bus.NOT;
        v[B_HISEL] = bus.hi_sel; v[B_DPRST] = bus.dp_reset; v[B_RUN] = bus.run;
        v[B_ILL] = bus.illegal;
        return v;
    endfunction

    // ALU strobe each opcode should raise, straight from the opcode table.
    function automatic logic [W-1:0] alu_of(input logic [4:0] op);
        case (op)
            5'd3, 5'd11:  return m(B_ADD);
            5'd4:         return m(B_SUB);
            5'd5:         return m(B_SHR);
            5'd6:         return m(B_SHL);
            5'd7:         return m(B_ROR);
            5'd8:         return m(B_ROL);
            5'd9, 5'd12:  return m(B_AND);
            5'd10, 5'd13: return m(B_OR);
            5'd14:        return m(B_MUL);
            5'd15:        return m(B_DIV);
            5'd16:        return m(B_NEG);
            5'd17:        return m(B_NOT);
            default:      return m(B_ADD);
        endcase
    endfunction

    function automatic int last_step(input logic [4:0] op);
        if (op >= 5'd1 && op <= 5'd15 && op != 5'd2) return 5;
        if (op == 5'd0 || op == 5'd2)                return 7;
        if (op == 5'd16 || op == 5'd17)              return 4;
        if (op == 5'd18)                             return 6;
        return 3;
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [4:0] op, input logic con_v, input int s);
        logic [W-1:0] w;
        w = m(B_RUN) | (exp_ill ? m(B_ILL) : '0);
        if (s == 0) return w | m(B_PCOUT) | m(B_MARIN) | m(B_INCPC) | m(B_RZIN);
        if (s == 1) return w | m(B_RZOUT) | m(B_PCIN) | m(B_READ) | m(B_MDRIN);
        if (s == 2) return w | m(B_MDROUT) | m(B_IRIN);
        if (op >= 5'd3 && op <= 5'd10) begin
            if (s == 3) w |= m(B_GRB) | m(B_ROUT) | m(B_RYIN);
            if (s == 4) w |= m(B_GRC) | m(B_ROUT) | alu_of(op) | m(B_RZIN);
            if (s == 5) w |= m(B_RZOUT) | m(B_GRA) | m(B_RIN);
        end else if (op == 5'd14 || op == 5'd15) begin
            if (s == 3) w |= m(B_GRA) | m(B_ROUT) | m(B_RYIN);
            if (s == 4) w |= m(B_GRB) | m(B_ROUT) | alu_of(op) | m(B_RZIN);
            if (s == 5) w |= m(B_RZOUT) | m(B_HILOIN);
        end else if (op == 5'd16 || op == 5'd17) begin
            if (s == 3) w |= m(B_GRB) | m(B_ROUT) | alu_of(op) | m(B_RZIN);
            if (s == 4) w |= m(B_RZOUT) | m(B_GRA) | m(B_RIN);
        end else if (op >= 5'd11 && op <= 5'd13) begin
            if (s == 3) w |= m(B_GRB) | m(B_ROUT) | m(B_RYIN);
            if (s == 4) w |= m(B_COUT) | alu_of(op) | m(B_RZIN);
            if (s == 5) w |= m(B_RZOUT) | m(B_GRA) | m(B_RIN);
        end else if (op <= 5'd2) begin
            if (s == 3) w |= m(B_GRB) | m(B_BAOUT) | m(B_RYIN);
            if (s == 4) w |= m(B_COUT) | m(B_ADD) | m(B_RZIN);
            if (s == 5 && op == 5'd1) w |= m(B_RZOUT) | m(B_GRA) | m(B_RIN);
            if (s == 5 && op != 5'd1) w |= m(B_RZOUT) | m(B_MARIN);
            if (s == 6 && op == 5'd0) w |= m(B_READ) | m(B_MDRIN);
            if (s == 7 && op == 5'd0) w |= m(B_MDROUT) | m(B_GRA) | m(B_RIN);
            if (s == 6 && op == 5'd2) w |= m(B_GRA) | m(B_ROUT) | m(B_MDRIN);
            if (s == 7 && op == 5'd2) w |= m(B_WRITE);
        end else if (op == 5'd18) begin
            if (s == 3) w |= m(B_GRA) | m(B_ROUT) | m(B_CONIN);
            if (s == 4) w |= m(B_PCOUT) | m(B_RYIN);
            if (s == 5) w |= m(B_COUT) | m(B_ADD) | m(B_RZIN);
            if (s == 6) w |= m(B_RZOUT) | (con_v ? m(B_PCIN) : '0);
        end else if (s == 3) begin
            case (op)
                5'd19: w |= m(B_GRA) | m(B_ROUT) | m(B_PCIN);
                5'd21: w |= m(B_INOUT) | m(B_GRA) | m(B_RIN);
                5'd22: w |= m(B_GRA) | m(B_ROUT) | m(B_OUTIN);
                5'd23: w |= m(B_HILOOUT) | m(B_HISEL) | m(B_GRA) | m(B_RIN);
                5'd24: w |= m(B_HILOOUT) | m(B_GRA) | m(B_RIN);
                default: ;
            endcase
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        bus.stop = 1'b0;
        exp_ill  = 1'b0;
        #1;
        check("rst_now", dut_word(), m(B_DPRST) | m(B_RUN));
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", dut_word(), m(B_DPRST) | m(B_RUN));
            check("rst_state", W'(bus.state), W'(S_RST));
        end
        reset = 1'b1;
    endtask

    // Entered just before the negedge of T0; ends at the negedge of the last execute state.
    task automatic run_instr(input string tag, input logic [31:0] ir_v, input logic con_v,
                             input logic stop_mid, input logic stop_last);
        logic [4:0]   op;
        logic [W-1:0] e;
        int           last;
        op      = ir_v[31:27];
        last    = last_step(op);
        bus.ir  = ir_v;
        bus.con = con_v;
        for (int s = 0; s <= last; s++) exp_q.push_back(exp_word(op, con_v, s));
        for (int s = 0; s <= last; s++) begin
            @(negedge clk);
            if (s == 0) check({tag, "_t0"}, W'(bus.state), W'(S_T0));
            e = exp_q.pop_front();
            check($sformatf("%s_s%0d", tag, s), dut_word(), e);
            bus.stop = (s == last) ? stop_last : stop_mid;
        end
    endtask

    task automatic hold_check(input string tag, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_ill ? m(B_ILL) : '0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check(tag, dut_word(), exp_q.pop_front());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_ill  = 1'b0;
        reset    = 1'b0;
        bus.ir   = '0;
        bus.con  = 1'b0;
        bus.stop = 1'b0;

        do_reset();
        run_instr("add", 32'h18918000, 1'b0, 1'b1, 1'b0);
        run_instr("add2", 32'h18918000, 1'b0, 1'b0, 1'b0);
        run_instr("br_t", 32'h91000023, 1'b1, 1'b0, 1'b0);
        run_instr("br_n", 32'h91000023, 1'b0, 1'b0, 1'b0);
        run_instr("ld", 32'h00800010, 1'b0, 1'b0, 1'b0);
        run_instr("st", {5'd2, 27'h0}, 1'b0, 1'b0, 1'b0);
        run_instr("ldi", {5'd1, 27'h5}, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [4:0] op;
            op = 5'(3 + $urandom_range(0, 22));
            if (op == 5'd20) op = 5'd25;
            run_instr($sformatf("rnd%0d_op%0d", i, op), {op, 27'(i)}, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        run_instr("mfhi", {5'd23, 27'h0}, 1'b0, 1'b0, 1'b0);
        run_instr("mflo", {5'd24, 27'h0}, 1'b0, 1'b0, 1'b0);
        run_instr("nop_stop", {5'd25, 27'h0}, 1'b0, 1'b0, 1'b1);
        hold_check("stop_halt", 3);

        do_reset();
        run_instr("halt", 32'hD0000000, 1'b0, 1'b0, 1'b0);
        hold_check("halt_hold", 20);

        do_reset();
        run_instr("jal", 32'hA0000000, 1'b0, 1'b0, 1'b0);
        exp_ill = 1'b1;
        hold_check("ill_hold", 4);

        do_reset();
        run_instr("ill_hi", {5'd31, 27'h0}, 1'b0, 1'b0, 1'b0);
        exp_ill = 1'b1;
        hold_check("ill_hi_hold", 2);

        // Abort an add in T4: outputs must collapse to the reset pattern before any edge.
        do_reset();
        bus.ir = 32'h18918000;
        for (int s = 0; s <= 4; s++) begin
            @(negedge clk);
            check($sformatf("abort_s%0d", s), dut_word(), exp_word(5'd3, 1'b0, s));
        end
        reset = 1'b0;
        #1;
        check("abort_now", dut_word(), m(B_DPRST) | m(B_RUN));
        do_reset();
        run_instr("after_abort", 32'h18918000, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
